// File: rtl/sbox_ctrl_pkg.sv
// rtl/sbox_ctrl_pkg.sv - shared state encoding and grant constants for the 2x1 switch-box arbiter
package sbox_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2,
    STATIC = 2'd3
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_P1   = 2'b01;
  localparam logic [1:0] GNT_P2   = 2'b10;

  // Select value 0 means producer 1, 1 means producer 2.
  function automatic logic [1:0] gnt_of_sel(input logic s);
    return s ? GNT_P2 : GNT_P1;
  endfunction

endpackage

// File: rtl/burst_counter.sv
// rtl/burst_counter.sv - per-grant token counter with clear, enable and burst-limit flag
module burst_counter #(
  parameter int MAX_BURST = 16,
  localparam int CNT_W = $clog2(MAX_BURST + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_max_hit
);

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(MAX_BURST - 1);

  logic [CNT_W-1:0] r_count;

  // High when the current enable is the token that completes the burst.
  assign o_max_hit = i_enable & (r_count == LAST_SLOT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sbox2x1_arbiter.sv
// rtl/sbox2x1_arbiter.sv - burst-limited round-robin select generator for a 2-to-1 merging switch box
module sbox2x1_arbiter
  import sbox_ctrl_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req1,
  input  logic       req2,
  input  logic       out_write,
  input  logic       out_full_n,
  input  logic       cfg_static,
  input  logic       cfg_sel,
  output logic       sel,
  output logic [1:0] grant,
  output logic       busy
);

  state_t     r_state;
  logic       r_sel;
  logic [1:0] r_grant;
  logic       r_busy;
  logic       r_last;

  state_t     w_state_nxt;
  logic       w_sel_nxt;
  logic [1:0] w_grant_nxt;
  logic       w_last_nxt;
  logic       w_xfer;
  logic       w_in_grant;
  logic       w_cnt_en;
  logic       w_cnt_clear;
  logic       w_max_hit;
  logic       w_own_req;
  logic       w_other_req;
  logic       w_do_grant;
  logic       w_grant_p;

  assign w_xfer      = out_write & out_full_n;
  assign w_in_grant  = (r_state == GRANT1) || (r_state == GRANT2);
  assign w_cnt_en    = w_xfer & w_in_grant;
  assign w_own_req   = (r_state == GRANT2) ? req2 : req1;
  assign w_other_req = (r_state == GRANT2) ? req1 : req2;

  burst_counter #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_counter (
    .i_clk     (clock),
    .i_rst_n   (reset),
    .i_clear   (w_cnt_clear),
    .i_enable  (w_cnt_en),
    .o_max_hit (w_max_hit)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_cnt_clear = 1'b1;
    w_do_grant  = 1'b0;
    w_grant_p   = 1'b0;

    case (r_state)
      IDLE: begin
        if (cfg_static) begin
          w_state_nxt = STATIC;
          w_sel_nxt   = cfg_sel;
          w_grant_nxt = gnt_of_sel(cfg_sel);
        end else if (req1 && req2) begin
          w_do_grant = 1'b1;
          w_grant_p  = ~r_last;
        end else if (req1 || req2) begin
          w_do_grant = 1'b1;
          w_grant_p  = ~req1;
        end else begin
          w_grant_nxt = GNT_NONE;
        end
      end

      GRANT1, GRANT2: begin
        w_cnt_clear = 1'b0;
        // Burst ends on the limit token or the first cycle the owner goes quiet.
        if (w_max_hit || !w_own_req) begin
          w_cnt_clear = 1'b1;
          if (cfg_static) begin
            w_state_nxt = STATIC;
            w_sel_nxt   = cfg_sel;
            w_grant_nxt = gnt_of_sel(cfg_sel);
          end else if (w_other_req) begin
            w_do_grant = 1'b1;
            w_grant_p  = (r_state == GRANT1);
          end else if (w_own_req) begin
            w_do_grant = 1'b1;
            w_grant_p  = (r_state == GRANT2);
          end else begin
            w_state_nxt = IDLE;
            w_grant_nxt = GNT_NONE;
          end
        end
      end

      STATIC: begin
        if (cfg_static) begin
          w_sel_nxt   = cfg_sel;
          w_grant_nxt = gnt_of_sel(cfg_sel);
        end else begin
          w_state_nxt = IDLE;
          w_grant_nxt = GNT_NONE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = GNT_NONE;
      end
    endcase

    if (w_do_grant) begin
      w_state_nxt = w_grant_p ? GRANT2 : GRANT1;
      w_sel_nxt   = w_grant_p;
      w_grant_nxt = gnt_of_sel(w_grant_p);
      w_last_nxt  = w_grant_p;
    end
  end

  // r_last = 1 out of reset marks producer 2 as most recent, so producer 1 wins the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
      r_grant <= GNT_NONE;
      r_busy  <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_grant <= w_grant_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_last  <= w_last_nxt;
    end
  end

  assign sel   = r_sel;
  assign grant = r_grant;
  assign busy  = r_busy;

endmodule
